// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM ingress packer.
//   state_t      : packer FSM states (IDLE / HI / LO)
//   *_DFLT       : default widths for metadata and its length field
//   BLK_W/BEAT_W : AES block width and ingress beat width
package aes_gcm_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  localparam int META_W_DFLT  = 289;
  localparam int LEN_LSB_DFLT = 33;
  localparam int LEN_W_DFLT   = 16;
  localparam int BLK_W        = 128;
  localparam int BEAT_W       = 64;
endpackage

// File: rtl/aes_keep_count.sv
// Byte-enable population count.
//   keep  : 8-bit contiguous byte enables (bit 7 = byte 0)
//   count : number of enabled bytes, 0..8
module aes_keep_count (
  input  logic [7:0] keep,
  output logic [3:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) count = count + {3'b000, keep[i]};
  end
endmodule

// File: rtl/aes_pkt_packer.sv
// Packs pairs of 64-bit packet beats into 128-bit plaintext blocks for the
// AES-GCM API, carries per-packet metadata alongside, and flags a mismatch
// between the received byte count and the metadata length field.
//   clk, rst_n            : clock, async active-low reset
//   s_valid/s_ready       : ingress handshake
//   s_data/s_keep/s_last  : beat payload, byte enables (last beat), end of packet
//   s_meta                : packet metadata, sampled on the first beat
//   i_hold                : downstream stall
//   o_new/o_last          : block strobe, final block of packet
//   o_plain_text          : packed block
//   o_bypass_text         : packet metadata
//   o_len_err             : byte count != length field (last block only)
module aes_pkt_packer
  import aes_gcm_pkg::*;
#(
  parameter int META_W  = META_W_DFLT,
  parameter int LEN_LSB = LEN_LSB_DFLT,
  parameter int LEN_W   = LEN_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [0:63]       s_data,
  input  logic [7:0]        s_keep,
  input  logic              s_last,
  input  logic [META_W-1:0] s_meta,
  input  logic              i_hold,
  output logic              o_new,
  output logic              o_last,
  output logic [0:127]      o_plain_text,
  output logic [META_W-1:0] o_bypass_text,
  output logic              o_len_err
);
  state_t              state, state_nx;
  logic [BEAT_W-1:0]   hi_q;
  logic [META_W-1:0]   meta_q;
  logic [LEN_W-1:0]    cnt_q;

  logic                p_vld, p_last, p_err;
  logic [BLK_W-1:0]    p_data;
  logic [META_W-1:0]   p_meta;

  logic [BEAT_W-1:0]   beat_raw, beat_m;
  logic [3:0]          keep_n, add;
  logic                first, accept, emit, load;
  logic [LEN_W-1:0]    cnt_base, cnt_sum;
  logic [LEN_W:0]      sum;
  logic [META_W-1:0]   meta_cur;
  logic                err_cur;
  logic [BLK_W-1:0]    blk;

  aes_keep_count u_keep_count (.keep(s_keep), .count(keep_n));

  // Re-index to [63:0] so beat_raw[63:56] is byte 0; keep bit k then
  // lines up with beat_raw[8k+7:8k]. Keep only masks on the last beat.
  assign beat_raw = s_data;
  always_comb begin
    beat_m = '0;
    for (int k = 0; k < 8; k++)
      beat_m[8*k +: 8] = beat_raw[8*k +: 8] & {8{~s_last | s_keep[k]}};
  end

  assign s_ready  = ~(p_vld & i_hold);
  assign accept   = s_valid & s_ready;
  assign emit     = p_vld & ~i_hold;
  assign first    = (state == IDLE);

  // Saturating byte count including the current beat.
  assign add      = s_last ? keep_n : 4'd8;
  assign cnt_base = first ? '0 : cnt_q;
  assign sum      = {1'b0, cnt_base} + {{(LEN_W-3){1'b0}}, add};
  assign cnt_sum  = sum[LEN_W] ? '1 : sum[LEN_W-1:0];

  // A packet's first block can complete on its first beat, so the meta
  // travelling with a block may have to come straight from the input.
  assign meta_cur = first ? s_meta : meta_q;
  assign err_cur  = (cnt_sum != meta_cur[LEN_LSB +: LEN_W]);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    blk      = '0;
    case (state)
      IDLE, HI: if (accept) begin
        if (s_last) begin
          load     = 1'b1;
          blk      = {beat_m, {BEAT_W{1'b0}}};
          state_nx = IDLE;
        end else begin
          state_nx = LO;
        end
      end
      LO: if (accept) begin
        load     = 1'b1;
        blk      = {hi_q, beat_m};
        state_nx = s_last ? IDLE : HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi_q   <= '0;
      meta_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) cnt_q <= cnt_sum;
      if (accept && state != LO) hi_q <= beat_m;
      if (accept && first) meta_q <= s_meta;
    end
  end

  // Pending slot: a new load wins over clearing on emission, which lets a
  // block leave and the next arrive on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
      p_err  <= 1'b0;
      p_data <= '0;
      p_meta <= '0;
    end else if (load) begin
      p_vld  <= 1'b1;
      p_last <= s_last;
      p_err  <= s_last & err_cur;
      p_data <= blk;
      p_meta <= meta_cur;
    end else if (emit) begin
      p_vld  <= 1'b0;
    end
  end

  assign o_new         = emit;
  assign o_last        = p_last;
  assign o_plain_text  = p_data;
  assign o_bypass_text = p_meta;
  assign o_len_err     = p_err;
endmodule

// File: tb/tb_aes_pkt_packer.sv
module tb_aes_pkt_packer;
  localparam int MW = 289;
  localparam int LL = 33;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [0:63]   s_data = '0;
  logic [7:0]    s_keep = '0;
  logic          s_last = 1'b0;
  logic [MW-1:0] s_meta = '0;
  logic          i_hold = 1'b0;
  logic          o_new, o_last, o_len_err;
  logic [0:127]  o_plain_text;
  logic [MW-1:0] o_bypass_text;

  aes_pkt_packer #(.META_W(MW), .LEN_LSB(LL), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_meta(s_meta),
    .i_hold(i_hold), .o_new(o_new), .o_last(o_last),
    .o_plain_text(o_plain_text), .o_bypass_text(o_bypass_text),
    .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [127:0]  d;
    logic          last;
    logic [MW-1:0] meta;
    logic          err;
  } blk_t;

  blk_t          expq[$];
  bit            pend = 0;
  int            pk_beats = 0, pk_bytes = 0;
  logic [MW-1:0] pk_meta;
  logic [63:0]   pk_hi;

  int            emit_cnt = 0;
  int            emit_cyc[$];
  logic [127:0]  last_d;
  logic          last_l, last_e;
  logic [MW-1:0] last_m;
  bit            rand_hold = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_o_new", 320'(o_new), 320'(0));
      chk("rst_s_ready", 320'(s_ready), 320'(1));
      chk("rst_o_last", 320'(o_last), 320'(0));
      chk("rst_o_len_err", 320'(o_len_err), 320'(0));
      chk("rst_o_plain", 320'(o_plain_text), 320'(0));
      chk("rst_o_bypass", 320'(o_bypass_text), 320'(0));
      expq.delete();
      pend = 0;
      pk_beats = 0;
    end else begin
      bit emit, acc, load;
      blk_t e;
      logic [63:0] raw, m;
      int nb;
      emit = pend && !i_hold;
      acc  = s_valid && !(pend && i_hold);
      load = 0;
      chk("s_ready", 320'(s_ready), 320'(!(pend && i_hold)));
      chk("o_new", 320'(o_new), 320'(emit));
      if (emit) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL model_underflow: block expected with empty queue");
        end else begin
          e = expq.pop_front();
          chk("blk_data", 320'(o_plain_text), 320'(e.d));
          chk("blk_last", 320'(o_last), 320'(e.last));
          chk("blk_meta", 320'(o_bypass_text), 320'(e.meta));
          chk("blk_len_err", 320'(o_len_err), 320'(e.err));
        end
      end
      if (o_new) begin
        emit_cnt++;
        emit_cyc.push_back(cyc);
        last_d = o_plain_text;
        last_l = o_last;
        last_e = o_len_err;
        last_m = o_bypass_text;
      end
      if (acc) begin
        raw = s_data;
        nb  = 0;
        for (int b = 0; b < 8; b++) begin
          // byte b of the beat is raw[63-8b -: 8]; its enable is s_keep[7-b]
          if (!s_last || s_keep[7-b]) begin
            m[63-8*b -: 8] = raw[63-8*b -: 8];
            nb++;
          end else begin
            m[63-8*b -: 8] = 8'h00;
          end
        end
        if (!s_last) nb = 8;
        if (pk_beats == 0) begin
          pk_meta  = s_meta;
          pk_bytes = 0;
        end
        pk_bytes += nb;
        e.meta = pk_meta;
        e.last = s_last;
        e.err  = s_last && (((pk_bytes > 65535) ? 65535 : pk_bytes) != int'(pk_meta[LL +: LW]));
        if (pk_beats % 2 == 1) begin
          e.d = {pk_hi, m}; expq.push_back(e); load = 1;
        end else if (s_last) begin
          e.d = {m, 64'h0}; expq.push_back(e); load = 1;
        end else begin
          pk_hi = m;
        end
        pk_beats = s_last ? 0 : pk_beats + 1;
      end
      pend = load ? 1'b1 : (emit ? 1'b0 : pend);
    end
  end

  always @(posedge clk) begin
    if (rand_hold) begin
      #1;
      i_hold = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  function automatic logic [MW-1:0] mk_meta(input int len);
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom;
    t[LL +: LW] = LW'(len);
    return t[MW-1:0];
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [MW-1:0] m, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; s_meta = m;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout: s_ready stayed 0 for 200 cycles");
    end
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input int nbytes, input logic [MW-1:0] meta, input int gap_max);
    int nbeat, rem;
    logic [7:0] k;
    nbeat = (nbytes + 7) / 8;
    for (int b = 0; b < nbeat; b++) begin
      rem = nbytes - 8 * b;
      k = (b == nbeat - 1) ? 8'(8'hFF << (8 - rem)) : 8'($urandom);
      send_beat({$urandom, $urandom}, k, b == nbeat - 1,
                (b == 0) ? meta : mk_meta($urandom_range(0, 100)),
                (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0]   d0, d1, d2, d3;
    logic [MW-1:0] ma, mb;
    int            n0;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 32-byte packet, 4 full beats
    d0 = 64'h0001020304050607; d1 = 64'h08090A0B0C0D0E0F;
    d2 = 64'h1011121314151617; d3 = 64'h18191A1B1C1D1E1F;
    ma = mk_meta(32); n0 = emit_cnt;
    send_beat(d0, 8'hFF, 0, ma, 0);
    send_beat(d1, 8'hFF, 0, ma, 0);
    send_beat(d2, 8'hFF, 0, ma, 0);
    send_beat(d3, 8'hFF, 1, ma, 0);
    drain();
    chk("t32_blocks", 320'(emit_cnt - n0), 320'(2));
    chk("t32_data", 320'(last_d), 320'(128'h101112131415161718191A1B1C1D1E1F));
    chk("t32_last", 320'(last_l), 320'(1));
    chk("t32_err", 320'(last_e), 320'(0));
    chk("t32_meta", 320'(last_m), 320'(ma));

    // 20-byte packet, last keep F0, garbage in dropped bytes
    ma = mk_meta(20); n0 = emit_cnt;
    send_beat(64'h0102030405060708, 8'h3C, 0, ma, 0);
    send_beat(64'h090A0B0C0D0E0F10, 8'h00, 0, ma, 0);
    send_beat(64'hA1A2A3A4A5A6A7A8, 8'hF0, 1, ma, 0);
    drain();
    chk("t20_blocks", 320'(emit_cnt - n0), 320'(2));
    chk("t20_data", 320'(last_d), 320'(128'hA1A2A3A4000000000000000000000000));
    chk("t20_last", 320'(last_l), 320'(1));
    chk("t20_err", 320'(last_e), 320'(0));

    // 8-byte single beat, length field says 9
    ma = mk_meta(9); n0 = emit_cnt;
    send_beat(64'h1122334455667788, 8'hFF, 1, ma, 0);
    drain();
    chk("t8_blocks", 320'(emit_cnt - n0), 320'(1));
    chk("t8_data", 320'(last_d), 320'(128'h11223344556677880000000000000000));
    chk("t8_last", 320'(last_l), 320'(1));
    chk("t8_err", 320'(last_e), 320'(1));

    // back-to-back packets with s_valid continuously high
    emit_cyc.delete();
    send_pkt(32, mk_meta(32), 0);
    send_pkt(32, mk_meta(32), 0);
    drain();
    chk("b2b_blocks", 320'(emit_cyc.size()), 320'(4));
    if (emit_cyc.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 320'(emit_cyc[i] - emit_cyc[i-1]), 320'(2));

    // downstream stall with a block pending
    ma = mk_meta(32); n0 = emit_cnt;
    i_hold = 1'b1;
    send_beat(d0, 8'hFF, 0, ma, 0);
    send_beat(d1, 8'hFF, 0, ma, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_s_ready", 320'(s_ready), 320'(0));
      chk("hold_o_new", 320'(o_new), 320'(0));
      chk("hold_data", 320'(o_plain_text), 320'({d0, d1}));
      @(posedge clk); #1;
    end
    i_hold = 1'b0;
    @(negedge clk);
    chk("hold_release_o_new", 320'(o_new), 320'(1));
    @(posedge clk); #1;
    send_beat(d2, 8'hFF, 0, ma, 0);
    send_beat(d3, 8'hFF, 1, ma, 0);
    drain();
    chk("hold_blocks", 320'(emit_cnt - n0), 320'(2));

    // async reset after the upper half of a block
    n0 = emit_cnt;
    send_beat(d0, 8'hFF, 0, mk_meta(16), 0);
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drain();
    chk("rst_no_block", 320'(emit_cnt - n0), 320'(0));
    mb = mk_meta(16);
    send_beat(64'hCAFEF00DDEADBEEF, 8'hFF, 0, mb, 0);
    send_beat(64'h0123456789ABCDEF, 8'hFF, 1, mk_meta(3), 0);
    drain();
    chk("rst_next_blocks", 320'(emit_cnt - n0), 320'(1));
    chk("rst_next_data", 320'(last_d), 320'(128'hCAFEF00DDEADBEEF0123456789ABCDEF));
    chk("rst_next_meta", 320'(last_m), 320'(mb));
    chk("rst_next_err", 320'(last_e), 320'(0));

    // randomized packets, random gaps and downstream stalls
    rand_hold = 1;
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = $urandom_range(1, 64);
      send_pkt(nb, mk_meta(($urandom_range(0, 3) == 0) ? nb + 1 : nb), 2);
    end
    rand_hold = 0;
    @(posedge clk); #2 i_hold = 1'b0;
    drain();

    // count saturation: 65544 bytes against a 65535 length field
    send_pkt(65544, mk_meta(65535), 0);
    drain();
    chk("sat_last", 320'(last_l), 320'(1));
    chk("sat_err", 320'(last_e), 320'(0));

    chk("queue_empty", 320'(expq.size()), 320'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_pkt_packer.md
# aes_pkt_packer

Ingress stage directly upstream of the AES-GCM API block. It accepts a 64-bit packet stream with valid/ready flow control and packs pairs of beats into 128-bit plaintext blocks. It drives the API's new/last/plain-text/bypass inputs. Per-packet metadata, including the 16-bit byte-length field the API uses to derive plaintext size, is captured on the first beat and held for the whole packet. The stage also checks the actual byte count against that length field.

## Interface
Parameters:
- META_W, 289, bypass/metadata width
- LEN_LSB, 33, LSB position of the length field inside metadata
- LEN_W, 16, length field width (bytes)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  [0:63]  beat data; bit 0 is MSB of byte 0
- s_keep  in  8  byte enables, only meaningful on s_last; s_keep[7] = byte 0; must be contiguous from byte 0
- s_last  in  1  final beat of packet
- s_meta  in  [META_W-1:0]  packet metadata, sampled on first beat only
- i_hold  in  1  downstream stall; suppresses emission
- o_new  out  1  block valid strobe, one cycle per block
- o_last  out  1  qualifies o_new: final block of packet
- o_plain_text  out  [0:127]  packed block
- o_bypass_text  out  [META_W-1:0]  packet metadata, constant across a packet
- o_len_err  out  1  with last block's o_new: byte count ≠ meta length field

## Operation
- States: IDLE (between packets), HI (waiting upper 64 bits), LO (upper half held, waiting lower 64 bits).
- IDLE, accepted beat:
  - latch s_meta;
  - byte count := 8, or popcount(s_keep) if s_last;
  - store beat as upper half;
  - go to LO, or complete block if s_last.
- HI, accepted beat: same as IDLE, but keeps the latched meta and adds to the count.
- LO, accepted beat:
  - beat becomes lower half, block completes;
  - next state HI, or IDLE if s_last.
- Completing on an upper-half s_last: lower 64 bits zero-padded.
- Bytes with s_keep=0 on the last beat are written as zero.
- Completed block loads the pending slot (p_vld=1) with data, last flag, meta and len-error flag.
  - For a first-beat block, meta comes straight from s_meta.
- Emission:
  - o_new = p_vld & ~i_hold, combinational from registers plus i_hold.
  - p_vld clears on emission unless a new block loads at the same edge.
- s_ready = ~(p_vld & i_hold).
  - Load and emission at the same edge is legal, which gives full throughput.
- Byte count is a LEN_W-bit register and saturates at all-ones.
- len_err = (final count ≠ meta[LEN_LSB+LEN_W-1:LEN_LSB]).
  - Evaluated on the last beat; emitted only with the last block.
- Single-beat and single-block packets: the block carries o_last=1, so the API's first-word state sees new & last together.

## Timing
- Reset values: s_ready=1 (since p_vld=0), o_new=0, o_last=0, o_plain_text=0, o_bypass_text=0, o_len_err=0; state IDLE; count 0.
- Latency: beat completing a block accepted at edge k → o_new high in cycle after k, if i_hold=0.
- Throughput: one block per two input beats; no bubbles while i_hold=0.
- i_hold high with p_vld: block and outputs frozen, s_ready=0; emission in first cycle i_hold falls.
- i_hold high without p_vld: input still accepted until a block completes.
- s_valid=0 mid-packet: state and partial block retained indefinitely.
- Reset mid-packet (async): partial block and pending block discarded, no o_new, next accepted beat treated as first of a new packet.
- o_last, o_plain_text, o_bypass_text, o_len_err are valid only when o_new=1.

## Structure
- Shared package aes_gcm_pkg:
  - state enum {IDLE, HI, LO};
  - META_W, LEN_LSB, LEN_W defaults;
  - block width 128, beat width 64.
- Sub-module aes_keep_count: 8-bit contiguous keep → 4-bit byte count (0..8), combinational.
- Packer FSM, count register and pending slot stay in one module.

## Test plan
- 32-byte packet, 4 beats, keep=FF, meta len=32, i_hold=0 → exactly 2 o_new, o_last only on 2nd, o_len_err=0, data bit-exact, bypass equals meta on both.
- 20-byte packet, 3 beats, last keep=F0, len=20 → 2 blocks; 2nd block bytes 4..15 zero, o_last=1, o_len_err=0.
- 8-byte packet, 1 beat, len=9 → single block, lower 64 bits zero, o_last=1, o_len_err=1.
- Back-to-back packets, s_valid always 1, i_hold=0 → o_new every 2nd cycle; second packet's meta replaces first exactly at its first block.
- i_hold held high for 5 cycles with block pending → s_ready=0, outputs stable; o_new in first cycle after release; no beat lost or duplicated.
- Assert rst_n low after the upper half of a block → o_new stays 0; next packet emits correct first block with new meta.
